// File: rtl/fir_out_requant_if.sv
// Sample stream in / requantised stream out of the FIR output stage.
// The master drives samples and the consumer ready; the slave is the stage.
interface fir_out_requant_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
);
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/fir_out_requant.sv
// FIR output stage: decimate, round/shift/saturate, then buffer in a
// show-ahead FIFO that drops (never stalls) when full.
module fir_out_requant #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 5,
    parameter int DECIM = 1,
    parameter int DEPTH = 8,
    localparam int LW = $clog2(DEPTH) + 1,
    localparam int AW = $clog2(DEPTH),
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    fir_out_requant_if.slave     io,
    input  logic                 clr_flags,
    output logic [LW-1:0]        fifo_level,
    output logic                 ovf_flag,
    output logic [15:0]          sat_count
);
    localparam logic [IN_W:0]    RND  = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic [OUT_W-1:0] MAXO = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MINO = {1'b1, {(OUT_W-1){1'b0}}};

    logic [PW-1:0]    phase_q, phase_d;
    logic             stg_v_q, stg_v_d;
    logic [OUT_W-1:0] stg_data_q, stg_data_d;
    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [OUT_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      sat_q, sat_d;

    logic                   keep;
    logic signed [IN_W:0]   t;
    logic signed [IN_W:0]   r;
    logic [IN_W-OUT_W+1:0]  hi;
    logic                   sat;
    logic [OUT_W-1:0]       clipped;
    logic                   pop;
    logic                   push;
    logic                   drop;

    // t is one bit wider than the input so adding the rounding bias never wraps
    always_comb begin
        keep    = io.in_valid && (phase_q == '0);
        t       = {io.in_data[IN_W-1], io.in_data} + RND;
        r       = t >>> SHIFT;
        hi      = r[IN_W:OUT_W-1];
        sat     = !((&hi) || (~|hi));
        clipped = r[OUT_W-1:0];
        if (sat) begin
            clipped = r[IN_W] ? MINO : MAXO;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (io.in_valid) begin
            phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
        end
        stg_v_d    = keep;
        stg_data_d = clipped;
    end

    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    always_comb begin
        pop      = (level_q != '0) && io.out_ready;
        push     = stg_v_q && ((level_q != LW'(DEPTH)) || pop);
        drop     = stg_v_q && !push;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = stg_data_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // set/increment events take priority over a coincident clear
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_flags) begin
            ovf_d = 1'b0;
        end
        sat_d = sat_q;
        if (keep && sat) begin
            if (clr_flags) begin
                sat_d = 16'd1;
            end else if (sat_q != 16'hFFFF) begin
                sat_d = sat_q + 16'd1;
            end
        end else if (clr_flags) begin
            sat_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q    <= '0;
            stg_v_q    <= 1'b0;
            stg_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            sat_q      <= '0;
        end else begin
            phase_q    <= phase_d;
            stg_v_q    <= stg_v_d;
            stg_data_q <= stg_data_d;
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            sat_q      <= sat_d;
        end
    end

    always_comb begin
        io.out_valid = (level_q != '0);
        io.out_data  = io.out_valid ? mem_q[rd_ptr_q] : '0;
        fifo_level   = level_q;
        ovf_flag     = ovf_q;
        sat_count    = sat_q;
    end
endmodule

// File: tb/tb_fir_out_requant.sv
// Bench for fir_out_requant: DECIM=1 and DECIM=4 instances share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_fir_out_requant;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clr_flags = 1'b0;
    always #5 clk = ~clk;

    fir_out_requant_if #(.IN_W(16), .OUT_W(8)) a_if ();
    fir_out_requant_if #(.IN_W(16), .OUT_W(8)) b_if ();

    logic [3:0]  lvl_a, lvl_b;
    logic        ovf_a, ovf_b;
    logic [15:0] sc_a, sc_b;

    fir_out_requant #(.DECIM(1)) u_a (
        .clk(clk), .reset(reset), .io(a_if.slave), .clr_flags(clr_flags),
        .fifo_level(lvl_a), .ovf_flag(ovf_a), .sat_count(sc_a)
    );
    fir_out_requant #(.DECIM(4)) u_b (
        .clk(clk), .reset(reset), .io(b_if.slave), .clr_flags(clr_flags),
        .fifo_level(lvl_b), .ovf_flag(ovf_b), .sat_count(sc_b)
    );

    int checks = 0;
    int failures = 0;

    int m_phase [2];
    int m_stg_v [2];
    int m_stg_d [2];
    int m_ovf [2];
    int m_sat [2];
    int mq [2][$];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // round half up then shift by 5, using integer division only
    function automatic int requant(input int d, output bit clip);
        int t;
        int r;
        t = d + 16;
        r = (t >= 0) ? t / 32 : -((-t + 31) / 32);
        clip = (r > 127) || (r < -128);
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_phase[u] = 0;
            m_stg_v[u] = 0;
            m_stg_d[u] = 0;
            m_ovf[u] = 0;
            m_sat[u] = 0;
            mq[u].delete();
        end
    endtask

    task automatic model_step(input int u, input bit iv, input int d,
                              input bit rdy, input bit clr);
        int dec;
        bit pop;
        bit push;
        bit clip;
        int v;
        dec = (u == 0) ? 1 : 4;
        pop = (mq[u].size() > 0) && rdy;
        push = (m_stg_v[u] != 0) && ((mq[u].size() < DEPTH) || pop);
        if (pop) void'(mq[u].pop_front());
        if (push) mq[u].push_back(m_stg_d[u]);
        if ((m_stg_v[u] != 0) && !push) m_ovf[u] = 1;
        else if (clr) m_ovf[u] = 0;
        v = requant(d, clip);
        if (iv && m_phase[u] == 0 && clip) begin
            m_sat[u] = clr ? 1 : ((m_sat[u] < 65535) ? m_sat[u] + 1 : 65535);
        end else if (clr) begin
            m_sat[u] = 0;
        end
        m_stg_v[u] = (iv && m_phase[u] == 0) ? 1 : 0;
        m_stg_d[u] = v;
        if (iv) m_phase[u] = (m_phase[u] + 1) % dec;
    endtask

    task automatic check_all();
        int ov;
        int od;
        int lv;
        int of;
        int sc;
        string nm;
        for (int u = 0; u < 2; u++) begin
            nm = (u == 0) ? "d1" : "d4";
            ov = (u == 0) ? int'(a_if.out_valid) : int'(b_if.out_valid);
            od = (u == 0) ? int'($signed(a_if.out_data))
                          : int'($signed(b_if.out_data));
            lv = (u == 0) ? int'(lvl_a) : int'(lvl_b);
            of = (u == 0) ? int'(ovf_a) : int'(ovf_b);
            sc = (u == 0) ? int'(sc_a) : int'(sc_b);
            chk({nm, "_out_valid"}, ov, (mq[u].size() > 0) ? 1 : 0);
            chk({nm, "_out_data"}, od, (mq[u].size() > 0) ? mq[u][0] : 0);
            chk({nm, "_fifo_level"}, lv, mq[u].size());
            chk({nm, "_ovf_flag"}, of, m_ovf[u]);
            chk({nm, "_sat_count"}, sc, m_sat[u]);
        end
    endtask

    task automatic drive(input bit iv, input int d, input bit rdy, input bit clr);
        a_if.in_valid = iv;
        a_if.in_data = 16'(d);
        a_if.out_ready = rdy;
        b_if.in_valid = iv;
        b_if.in_data = 16'(d);
        b_if.out_ready = rdy;
        clr_flags = clr;
    endtask

    task automatic cyc(input bit iv, input int d, input bit rdy, input bit clr);
        @(negedge clk);
        check_all();
        drive(iv, d, rdy, clr);
        model_step(0, iv, d, rdy, clr);
        model_step(1, iv, d, rdy, clr);
    endtask

    initial begin
        drive(0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // rounding
        cyc(1, 100, 1, 0);
        cyc(1, -100, 1, 0);
        cyc(1, 48, 1, 0);
        cyc(1, -48, 1, 0);
        cyc(1, 0, 1, 0);
        repeat (4) cyc(0, 0, 1, 0);

        // saturation, then clear
        cyc(1, 12800, 1, 0);
        cyc(1, -12800, 1, 0);
        cyc(1, 4080, 1, 0);
        repeat (3) cyc(0, 0, 1, 0);
        chk("sat_count_three", int'(sc_a), 3);
        cyc(0, 0, 1, 1);
        repeat (2) cyc(0, 0, 1, 0);

        // decimation ramp with a gap in the middle
        for (int k = 0; k < 6; k++) cyc(1, k * 32, 1, 0);
        cyc(0, 9999, 1, 0);
        cyc(0, 9999, 1, 0);
        for (int k = 6; k < 12; k++) cyc(1, k * 32, 1, 0);
        repeat (4) cyc(0, 0, 1, 0);

        // backpressure and overflow
        for (int k = 1; k <= 10; k++) cyc(1, k * 32, 0, 0);
        repeat (2) cyc(0, 0, 0, 0);
        @(negedge clk);
        chk("bp_level_full", int'(lvl_a), 8);
        chk("bp_ovf_set", int'(ovf_a), 1);
        repeat (10) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);

        // full FIFO with simultaneous pop
        for (int k = 1; k <= 8; k++) cyc(1, k * 32, 0, 0);
        cyc(0, 0, 0, 0);
        for (int k = 9; k <= 30; k++) cyc(1, k * 32, 1, 0);
        chk("fullpop_no_ovf", int'(ovf_a), 0);
        repeat (12) cyc(0, 0, 1, 0);

        // build level 5, ovf=1, sat=2, then reset between edges
        cyc(0, 0, 1, 1);
        cyc(1, 12800, 0, 0);
        cyc(1, -12800, 0, 0);
        for (int k = 3; k <= 10; k++) cyc(1, k * 32, 0, 0);
        repeat (2) cyc(0, 0, 0, 0);
        repeat (3) cyc(0, 0, 1, 0);
        @(negedge clk);
        check_all();
        drive(0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", int'(a_if.out_valid), 0);
        chk("rst_out_data", int'($signed(a_if.out_data)), 0);
        chk("rst_fifo_level", int'(lvl_a), 0);
        chk("rst_ovf_flag", int'(ovf_a), 0);
        chk("rst_sat_count", int'(sc_a), 0);
        chk("rst_b_fifo_level", int'(lvl_b), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) cyc(1, k * 32, 1, 0);
        repeat (4) cyc(0, 0, 1, 0);

        // randomized traffic with bursts of backpressure
        for (int n = 0; n < 1500; n++) begin
            bit iv;
            bit rdy;
            bit clr;
            int d;
            iv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) d = int'($signed(16'($urandom)));
            else d = $urandom_range(0, 8000) - 4000;
            rdy = ((n / 40) % 3 == 1) ? ($urandom_range(0, 7) == 0)
                                      : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 63) == 0);
            cyc(iv, d, rdy, clr);
        end
        repeat (12) cyc(0, 0, 1, 0);
        @(negedge clk);
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
- Downstream stage of the 8-tap FIR filter; consumes its 16-bit signed `filter_out` sample stream.
- Optionally decimates the stream by DECIM, then rounds and right-shifts by SHIFT and saturates to OUT_W bits.
- Buffers results in a DEPTH-entry FIFO and presents them on a valid/ready output interface.
- Reports overflow (dropped samples) and saturation statistics.

Parameters:
- IN_W, 16, input sample width (signed two's complement).
- OUT_W, 8, output sample width (signed); legal range 2..IN_W-1.
- SHIFT, 5, arithmetic right-shift applied after rounding; legal range 1..IN_W-1.
- DECIM, 1, decimation factor; keep one of every DECIM valid samples; DECIM >= 1.
- DEPTH, 8, FIFO depth; must be a power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a new sample this cycle. Tie to 1 when fed directly by the FIR.
- in_data  in  IN_W  signed input sample (the FIR `filter_out`).
- clr_flags  in  1  synchronous clear of ovf_flag and sat_count.
- out_valid  out  1  FIFO head holds a valid sample.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  OUT_W  signed FIFO head; forced to 0 when out_valid=0.
- fifo_level  out  $clog2(DEPTH)+1  number of entries currently stored.
- ovf_flag  out  1  sticky; set when a processed sample is dropped because the FIFO is full.
- sat_count  out  16  number of kept samples that were clipped; saturates at 0xFFFF.

Behaviour:
- Reset (asynchronous, takes effect immediately) clears:
  - out_valid=0, out_data=0, fifo_level=0, ovf_flag=0, sat_count=0.
  - decimation phase=0, stage register invalid, FIFO pointers=0.
- Reset asserted mid-operation discards all buffered data.

Decimation:
- 0..DECIM-1 phase counter advances only on in_valid; wraps from DECIM-1 to 0.
- A sample is kept only when in_valid=1 and phase=0.
- With DECIM=1 every sample is kept.

Arithmetic (combinational, on the kept sample):
- t = sign_extend(in_data, IN_W+1) + 2^(SHIFT-1), computed at IN_W+1 bits so it cannot wrap.
- r = t >>> SHIFT (arithmetic shift): round-half-up toward +infinity.
- If r > 2^(OUT_W-1)-1, output is 2^(OUT_W-1)-1; if r < -2^(OUT_W-1), output is -2^(OUT_W-1); otherwise output is r.
- Each clipped kept sample increments sat_count by 1, saturating at 0xFFFF.

Pipeline:
- Kept sample in cycle t is registered into the stage register at the end of cycle t.
- It is pushed into the FIFO at the end of cycle t+1.
- out_valid rises in cycle t+2 if the FIFO was empty. Latency = 2 cycles.
- The pipeline sustains one sample per cycle.

FIFO:
- Show-ahead: out_data always reflects the head entry.
- Pop occurs when out_valid & out_ready.
- Push occurs when the stage register is valid and (fifo_level < DEPTH, or a pop happens in the same cycle).
  - Push and pop in the same cycle when full: both occur and fifo_level is unchanged.
- If the stage register is valid, the FIFO is full and there is no pop: the sample is dropped and ovf_flag is set.
  - The stage register never stalls, and the upstream stream is never throttled.
- Empty: out_valid=0; out_ready is ignored; fifo_level never underflows.
- Pointers wrap modulo DEPTH; data order is strictly FIFO.

Flags:
- clr_flags clears ovf_flag and sat_count at the next edge.
- If a set/increment event coincides with clr_flags, the event wins: ovf_flag=1 / sat_count=1.

Test Plan:
- Rounding (DECIM=1, SHIFT=5, out_ready=1): in_data 100, -100, 48, -48, 0 on consecutive cycles -> out_data 3, -3, 2, -1, 0; first out_valid exactly 2 cycles after first in_valid; sat_count stays 0.
- Saturation: in_data 12800, then -12800, then 4080 -> out_data 127, -128, 127 (4080 rounds to 128, clipped); sat_count=3; then clr_flags pulse -> sat_count=0.
- Decimation (DECIM=4): continuous in_valid with in_data=k*32 for k=0..11 -> out_data 0, 4, 8 only; inserting an in_valid=0 gap does not advance the phase.
- Backpressure/overflow (DEPTH=8): out_ready=0, 10 consecutive samples 1*32..10*32 -> fifo_level reaches 8, ovf_flag=1; raising out_ready drains 1..8 in order; samples 9 and 10 are lost.
- Full with simultaneous pop: FIFO full, out_ready=1, continuous input -> no drops, ovf_flag stays 0, fifo_level stays 8, output sequence contiguous.
- Reset mid-stream: fifo_level=5, ovf_flag=1, sat_count=2; assert reset between edges -> out_valid, out_data, fifo_level, ovf_flag, sat_count go to 0 immediately; first kept sample after release is the first in_valid (phase 0).
